// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtract sequencer.
package sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_ctrl_if.sv
// Command/result bundle: master issues start with operands, slave returns the difference.
interface nibble_serial_sub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = sub_pkg::NIB_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow, zero
  );

endinterface

// File: rtl/sub4_slice.sv
// 4-bit ripple adder with exposed carry-in/out; the caller inverts the subtrahend.
module sub4_slice
  import sub_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Serial A-B over NIBBLES cycles through one shared 4-bit slice, LSB nibble first.
// done pulses in the DONE state, with diff/borrow/zero already settled.
module nibble_serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_sub_ctrl_if.slave  bus
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       op_a_q, op_b_q, diff_q, diff_d;
  logic               borrow_q, zero_q, done_q;

  logic [NIB_W-1:0]   slice_x, slice_y, slice_s;
  logic               slice_cout;
  logic               last_nib;

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.busy  = (state_q == RUN);
  end

  always_comb begin
    slice_x = '0;
    slice_y = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_x = op_a_q[i*NIB_W +: NIB_W];
        slice_y = ~op_b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  always_comb begin
    diff_d = diff_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) diff_d[i*NIB_W +: NIB_W] = slice_s;
    end
  end

  sub4_slice u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Flags are captured from the final slice on the edge into DONE so they
  // are valid alongside the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_a_q   <= bus.a;
            op_b_q   <= bus.b;
            diff_q   <= '0;
            carry_q  <= 1'b1;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
          end
        end
        RUN: begin
          diff_q  <= diff_d;
          carry_q <= slice_cout;
          if (last_nib) begin
            borrow_q <= ~slice_cout;
            zero_q   <= (diff_d == '0);
            done_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;

endmodule
